// File: rtl/arith_engine_seq.sv
// Registered add/sub/accumulate/clear engine with valid/ready handshakes on both sides
// and a selectable overflow policy (force zero, wrap, saturate).
module arith_engine_seq #(
  parameter int WIDTH    = 4,
  parameter int OVF_MODE = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [1:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Ovf,
  output logic             OvfSticky,
  output logic [WIDTH-1:0] AccValue
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;

  // Unsupported policy codes fall back to force-zero
  localparam int MODE = ((OVF_MODE == 1) || (OVF_MODE == 2)) ? OVF_MODE : 0;

  state_t           state_r, state_s;
  logic             accept_s;
  logic [WIDTH-1:0] a_r, b_r, acc_r, result_r;
  logic [1:0]       op_r;
  logic             ovf_r, sticky_r, in_ready_r, out_valid_r;
  logic [WIDTH:0]   wide_s;
  logic             raw_ovf_s, is_sub_s, clr_s;
  logic [WIDTH-1:0] res_s;

  function automatic logic [WIDTH-1:0] apply_policy(input logic [WIDTH-1:0] low,
                                                    input logic ovf,
                                                    input logic is_sub);
    logic [WIDTH-1:0] r;
    if (!ovf) begin
      r = low;
    end else begin
      case (MODE)
        1:       r = low;
        2:       r = is_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        default: r = {WIDTH{1'b0}};
      endcase
    end
    return r;
  endfunction

  // Next-state and request acceptance
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (InValid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = ST_CALC;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_CALC: state_s = ST_HOLD;
      ST_HOLD: begin
        if (OutReady) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Arithmetic on the latched request; WIDTH+1 bits expose carry/borrow
  always_comb begin
    wide_s    = {(WIDTH+1){1'b0}};
    raw_ovf_s = 1'b0;
    is_sub_s  = 1'b0;
    clr_s     = 1'b0;
    case (op_r)
      OP_ADD: begin
        wide_s    = {1'b0, a_r} + {1'b0, b_r};
        raw_ovf_s = wide_s[WIDTH];
      end
      OP_SUB: begin
        wide_s    = {1'b0, a_r} - {1'b0, b_r};
        raw_ovf_s = (b_r > a_r);
        is_sub_s  = 1'b1;
      end
      OP_ACC: begin
        wide_s    = {1'b0, acc_r} + {1'b0, a_r};
        raw_ovf_s = wide_s[WIDTH];
      end
      default: clr_s = 1'b1;
    endcase
    res_s = apply_policy(wide_s[WIDTH-1:0], raw_ovf_s, is_sub_s);
  end

  // State, handshake flags, operand latch and result registers
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 2'b00;
      result_r    <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      sticky_r    <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_HOLD);
      if (accept_s) begin
        a_r  <= OpA;
        b_r  <= OpB;
        op_r <= Op;
      end
      if (state_r == ST_CALC) begin
        result_r <= res_s;
        ovf_r    <= raw_ovf_s;
        if (clr_s) begin
          acc_r    <= {WIDTH{1'b0}};
          sticky_r <= 1'b0;
        end else begin
          if (op_r == OP_ACC) begin
            acc_r <= res_s;
          end
          if (raw_ovf_s) begin
            sticky_r <= 1'b1;
          end
        end
      end
    end
  end

  assign InReady   = in_ready_r;
  assign OutValid  = out_valid_r;
  assign Result    = result_r;
  assign Ovf       = ovf_r;
  assign OvfSticky = sticky_r;
  assign AccValue  = acc_r;

endmodule
